// File: rtl/cardinal_pkg.sv
// rtl/cardinal_pkg.sv - shared constants for the cardinal NIC
package cardinal_pkg;

    // Processor register map
    localparam logic [1:0] ADDR_IBUF  = 2'b00;
    localparam logic [1:0] ADDR_ISTAT = 2'b01;
    localparam logic [1:0] ADDR_OBUF  = 2'b10;
    localparam logic [1:0] ADDR_OSTAT = 2'b11;

    // Virtual-channel bit of a default-width packet (its MSB)
    localparam int VC_BIT = 63;

    // Bit of a status read word that carries the full flag
    localparam int STATUS_FULL = 0;

endpackage

// File: rtl/cardinal_nic_chan.sv
// rtl/cardinal_nic_chan.sv - one-entry buffer with full flag
module cardinal_nic_chan #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  full
);

    // Load captures data and marks full; clear only drops the flag so data stays readable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// rtl/cardinal_nic.sv - processor-to-router PE port network interface
module cardinal_nic
    import cardinal_pkg::*;
#(
    parameter int DATA_WIDTH = VC_BIT + 1,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    input  logic                  net_polarity
);

    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] ibuf;
    logic [DATA_WIDTH-1:0] obuf;
    logic                  in_full;
    logic                  out_full;
    logic                  in_load;
    logic                  in_clear;
    logic                  out_load;
    logic                  out_clear;
    logic [DATA_WIDTH-1:0] rd_data;

    assign rd_en = nicEn & ~nicWrEn;
    assign wr_en = nicEn & nicWrEn;

    // Router side: accept only when empty; send only when the router polarity matches the packet VC
    assign net_ri = ~in_full;
    assign net_do = obuf;
    assign net_so = out_full & (net_polarity == obuf[DATA_WIDTH-1]);

    // Flag updates use pre-edge state, so a write racing a drain is still dropped
    assign in_load   = net_si & ~in_full;
    assign in_clear  = rd_en & (addr == ADDR_IBUF) & in_full;
    assign out_load  = wr_en & (addr == ADDR_OBUF) & ~out_full;
    assign out_clear = net_so & net_ro;

    cardinal_nic_chan #(.DATA_WIDTH(DATA_WIDTH)) u_in_chan (
        .clk       (clk),
        .rst       (rst),
        .load      (in_load),
        .load_data (net_di),
        .clear     (in_clear),
        .data      (ibuf),
        .full      (in_full)
    );

    cardinal_nic_chan #(.DATA_WIDTH(DATA_WIDTH)) u_out_chan (
        .clk       (clk),
        .rst       (rst),
        .load      (out_load),
        .load_data (d_in),
        .clear     (out_clear),
        .data      (obuf),
        .full      (out_full)
    );

    // Read mux: buffers return data, status registers return the flag in the status bit
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_IBUF:  rd_data = ibuf;
            ADDR_ISTAT: rd_data[STATUS_FULL] = in_full;
            ADDR_OBUF:  rd_data = obuf;
            ADDR_OSTAT: rd_data[STATUS_FULL] = out_full;
            default:    rd_data = '0;
        endcase
    end

    // Registered read data; holds when there is no read access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// tb/tb_cardinal_nic.sv - directed self-checking bench for cardinal_nic
module tb_cardinal_nic;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_polarity;

    int n_tests;
    int n_fail;

    cardinal_nic dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nic_write(input logic [1:0] a, input logic [63:0] v);
        addr    = a;
        d_in    = v;
        nicEn   = 1'b1;
        nicWrEn = 1'b1;
        step();
        nicEn   = 1'b0;
        nicWrEn = 1'b0;
    endtask

    task automatic nic_read(input logic [1:0] a);
        addr    = a;
        nicEn   = 1'b1;
        nicWrEn = 1'b0;
        step();
        nicEn   = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_ro = 1'b0; net_si = 1'b0; net_di = '0; net_polarity = 1'b0;

        // Reset state
        step(); step();
        check("rst_dout", d_out, 64'h0);
        check("rst_so", {63'b0, net_so}, 64'h0);
        check("rst_ri", {63'b0, net_ri}, 64'h1);
        check("rst_do", net_do, 64'h0);
        rst = 1'b1;
        step();

        // Send: drained one edge after the write
        net_ro = 1'b1;
        nic_write(2'b10, 64'h0000_0000_0000_00A5);
        check("send_so", {63'b0, net_so}, 64'h1);
        check("send_do", net_do, 64'hA5);
        step();
        check("send_so_drained", {63'b0, net_so}, 64'h0);
        check("send_do_kept", net_do, 64'hA5);
        nic_read(2'b11);
        check("send_ostat", d_out, 64'h0);

        // Polarity gate
        nic_write(2'b10, 64'h8000_0000_0000_0033);
        check("pol_gated", {63'b0, net_so}, 64'h0);
        nic_read(2'b11);
        check("pol_ostat_full", d_out, 64'h1);
        check("pol_still_gated", {63'b0, net_so}, 64'h0);
        net_polarity = 1'b1;
        #1;
        check("pol_open", {63'b0, net_so}, 64'h1);
        step();
        check("pol_drained", {63'b0, net_so}, 64'h0);
        net_polarity = 1'b0;
        nic_read(2'b11);
        check("pol_ostat_empty", d_out, 64'h0);

        // Receive
        net_si = 1'b1;
        net_di = 64'hDEAD_BEEF_0000_0001;
        step();
        net_si = 1'b0;
        check("rx_ri_low", {63'b0, net_ri}, 64'h0);
        nic_read(2'b01);
        check("rx_istat", d_out, 64'h1);
        nic_read(2'b00);
        check("rx_data", d_out, 64'hDEAD_BEEF_0000_0001);
        check("rx_ri_high", {63'b0, net_ri}, 64'h1);
        nic_read(2'b01);
        check("rx_istat_empty", d_out, 64'h0);

        // Full drop, including a write on the same edge as the drain
        net_ro = 1'b0;
        nic_write(2'b10, 64'h11);
        nic_write(2'b10, 64'h22);
        check("drop_do", net_do, 64'h11);
        nic_read(2'b10);
        check("drop_obuf", d_out, 64'h11);
        check("drop_so_wait", {63'b0, net_so}, 64'h1);
        net_ro = 1'b1;
        nic_write(2'b10, 64'h44);
        check("drop_race_so", {63'b0, net_so}, 64'h0);
        check("drop_race_do", net_do, 64'h11);
        step();
        check("drop_sent_once", {63'b0, net_so}, 64'h0);
        net_ro = 1'b0;

        // Back-pressure
        net_si = 1'b1;
        net_di = 64'h100;
        step();
        net_di = 64'h200;
        step(); step(); step();
        check("bp_ri_low", {63'b0, net_ri}, 64'h0);
        nic_read(2'b00);
        check("bp_first", d_out, 64'h100);
        check("bp_ri_rise", {63'b0, net_ri}, 64'h1);
        step();
        net_si = 1'b0;
        check("bp_captured", {63'b0, net_ri}, 64'h0);
        nic_read(2'b00);
        check("bp_second", d_out, 64'h200);

        // Mid-operation reset is asynchronous
        nic_write(2'b10, 64'h55);
        net_si = 1'b1;
        net_di = 64'h66;
        nic_read(2'b10);
        net_si = 1'b0;
        check("mid_pre_dout", d_out, 64'h55);
        check("mid_pre_so", {63'b0, net_so}, 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_dout", d_out, 64'h0);
        check("mid_so", {63'b0, net_so}, 64'h0);
        check("mid_ri", {63'b0, net_ri}, 64'h1);
        check("mid_do", net_do, 64'h0);
        step();
        rst = 1'b1;
        step();
        nic_read(2'b11);
        check("mid_ostat", d_out, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
